alu_sequencer: RTL and testbench

Command sequencer that sits in front of the ALU accumulator datapath and drives its `A`, `B`, `muxAInput`, `muxBInput` and `op` inputs. Upstream requesters push operation commands through a 4-deep command FIFO with a valid/ready handshake. The sequencer issues one command at a time, waits for the accumulator to update, and returns the result with an error flag. It also predicts subtract-underflow and divide-by-zero before issue, so the ALU never produces an X result. The Ready/Error state is held here in synthesizable form rather than in the testbench.

---
 rtl/alu_pkg.sv | 43 ++++
 rtl/cmd_fifo.sv | 47 ++++
 rtl/alu_sequencer.sv | 153 +++++++++++++++
 tb/tb_alu_sequencer.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, ALU mux selects, command layout and sequencer states for alu_sequencer.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_NOT = 4'd7;
  localparam logic [3:0] OP_SHL = 4'd8;
  localparam logic [3:0] OP_SHR = 4'd9;
  localparam logic [3:0] OP_INC = 4'd10;
  localparam logic [3:0] OP_DEC = 4'd11;
  localparam logic [3:0] OP_CMP = 4'd12;
  localparam logic [3:0] OP_NOP = 4'd13;
  localparam logic [3:0] OP_RST = 4'd14;

  localparam logic [1:0] MUXA_LOAD = 2'b10;
  localparam logic [1:0] MUXA_HOLD = 2'b01;
  localparam logic [3:0] MUXB_ZERO = 4'b1000;
  localparam logic [3:0] MUXB_B    = 4'b0100;
  localparam logic [3:0] MUXB_ACC  = 4'b0010;
  localparam logic [3:0] MUXB_HOLD = 4'b0001;

  typedef struct packed {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        bsel;
  } cmd_t;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} seq_state_e;

  // Commands the ALU must never see: unsigned underflow, divide by zero, undefined opcode.
  function automatic logic is_fault(input logic [3:0] op, input logic [15:0] a,
                                    input logic [15:0] eff_b);
    return ((op == OP_SUB) && (eff_b > a)) || ((op == OP_DIV) && (eff_b == 16'd0)) ||
           (op == 4'd15);
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Parameterised synchronous FIFO with async active-low reset; caller never pushes full or pops empty.
module cmd_fifo #(
  parameter int unsigned WIDTH = 37,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCnt = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;

  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

  // Power-of-two depth lets the pointers wrap on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + AW'(1);
      if (i_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + {{AW{1'b0}}, i_push} - {{AW{1'b0}}, i_pop};
    end
  end

  assign o_rdata = r_mem[r_rptr];
  assign o_full  = (r_count == FullCnt);
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/alu_sequencer.sv
// Queues ALU commands, screens out faulting ones before issue, drives the accumulator datapath
// one command at a time and returns each result with an error flag.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [15:0] cmd_a,
  input  logic [15:0] cmd_b,
  input  logic        cmd_bsel,
  output logic [15:0] alu_A,
  output logic [15:0] alu_B,
  output logic [1:0]  alu_muxA,
  output logic [3:0]  alu_muxB,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_acc,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        busy,
  output logic        err_state
);

  localparam int unsigned LatW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [LatW-1:0] LatLast = LatW'(ALU_LAT - 1);

  seq_state_e      r_state;
  logic            r_skip;
  logic            r_err_state;
  logic [LatW-1:0] r_lat_cnt;
  logic [15:0]     r_alu_a;
  logic [15:0]     r_alu_b;
  logic [3:0]      r_alu_op;
  logic [1:0]      r_mux_a;
  logic [3:0]      r_mux_b;
  logic [31:0]     r_rsp_data;
  logic            r_rsp_err;

  cmd_t        w_wdata;
  cmd_t        w_head;
  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_pop;
  logic        w_reject;
  logic [15:0] w_eff_b;

  assign w_wdata = '{op: cmd_op, a: cmd_a, b: cmd_b, bsel: cmd_bsel};
  assign w_push  = cmd_valid && !w_full;
  assign w_pop   = (r_state == StIdle) && !w_empty;
  assign w_eff_b = w_head.bsel ? alu_acc[15:0] : w_head.b;
  // While the error flag is up only a reset opcode gets through.
  assign w_reject = r_err_state ? (w_head.op != OP_RST)
                                : is_fault(w_head.op, w_head.a, w_eff_b);

  cmd_fifo #(
    .WIDTH($bits(cmd_t)),
    .DEPTH(DEPTH)
  ) u_cmd_fifo (
    .clk    (clk),
    .rst_n  (reset),
    .i_push (w_push),
    .i_wdata(w_wdata),
    .i_pop  (w_pop),
    .o_rdata(w_head),
    .o_full (w_full),
    .o_empty(w_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= StIdle;
      r_skip      <= 1'b0;
      r_err_state <= 1'b0;
      r_lat_cnt   <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_op    <= OP_RST;
      r_mux_a     <= MUXA_HOLD;
      r_mux_b     <= MUXB_ZERO;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_alu_op <= OP_NOP;
          r_mux_a  <= MUXA_HOLD;
          r_mux_b  <= MUXB_HOLD;
          if (w_pop) begin
            r_state <= StIssue;
            r_skip  <= w_reject;
            if (w_reject) begin
              r_err_state <= 1'b1;
            end else begin
              r_err_state <= 1'b0;
              r_alu_a     <= w_head.a;
              r_alu_b     <= w_head.b;
              r_alu_op    <= w_head.op;
              r_mux_a     <= MUXA_LOAD;
              if (w_head.op == OP_RST) r_mux_b <= MUXB_ZERO;
              else                     r_mux_b <= w_head.bsel ? MUXB_ACC : MUXB_B;
            end
          end
        end
        StIssue: begin
          r_mux_a   <= MUXA_HOLD;
          r_mux_b   <= MUXB_HOLD;
          r_lat_cnt <= '0;
          if (r_skip) begin
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b1;
            r_state    <= StResp;
          end else begin
            r_state <= StWait;
          end
        end
        StWait: begin
          if (r_lat_cnt == LatLast) begin
            r_rsp_data <= alu_acc;
            r_rsp_err  <= 1'b0;
            r_alu_op   <= OP_NOP;
            r_state    <= StResp;
          end else begin
            r_lat_cnt <= r_lat_cnt + LatW'(1);
          end
        end
        StResp: begin
          if (rsp_ready) r_state <= StIdle;
        end
      endcase
    end
  end

  assign cmd_ready = !w_full;
  assign alu_A     = r_alu_a;
  assign alu_B     = r_alu_b;
  assign alu_op    = r_alu_op;
  assign alu_muxA  = r_mux_a;
  assign alu_muxB  = r_mux_b;
  assign rsp_valid = (r_state == StResp);
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;
  assign busy      = (r_state != StIdle) || !w_empty;
  assign err_state = r_err_state;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench: a command-level reference model predicts each response, a monitor checks them.
module tb_alu_sequencer;

  localparam int DEPTH   = 4;
  localparam int ALU_LAT = 1;

  logic        clk       = 1'b0;
  logic        reset     = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_op    = '0;
  logic [15:0] cmd_a     = '0;
  logic [15:0] cmd_b     = '0;
  logic        cmd_bsel  = 1'b0;
  logic [15:0] alu_A, alu_B;
  logic [1:0]  alu_muxA;
  logic [3:0]  alu_muxB, alu_op;
  logic [31:0] alu_acc;
  logic [31:0] env_acc;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_data;
  logic        rsp_err, busy, err_state;

  int rdy_mode    = 1;
  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic        errst;
  } exp_t;
  exp_t exp_q[$];

  logic [31:0] m_acc = '0;
  bit          m_err = 1'b0;

  alu_sequencer #(
    .DEPTH  (DEPTH),
    .ALU_LAT(ALU_LAT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_a    (cmd_a),
    .cmd_b    (cmd_b),
    .cmd_bsel (cmd_bsel),
    .alu_A    (alu_A),
    .alu_B    (alu_B),
    .alu_muxA (alu_muxA),
    .alu_muxB (alu_muxB),
    .alu_op   (alu_op),
    .alu_acc  (alu_acc),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
    .rsp_err  (rsp_err),
    .busy     (busy),
    .err_state(err_state)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] arith(input logic [3:0] op, input logic [15:0] a,
                                        input logic [15:0] b, input logic [31:0] acc);
    case (op)
      4'd0:    return {16'h0, a} + {16'h0, b};
      4'd1:    return {16'h0, a} - {16'h0, b};
      4'd2:    return {16'h0, a} * {16'h0, b};
      4'd3:    return (b == 16'h0) ? 32'h0 : {16'h0, a} / {16'h0, b};
      4'd14:   return 32'h0;
      default: return acc;
    endcase
  endfunction

  function automatic logic [15:0] opb_sel(input logic [3:0] mb, input logic [15:0] b,
                                          input logic [31:0] acc);
    case (mb)
      4'b0100: return b;
      4'b0010: return acc[15:0];
      default: return 16'h0;
    endcase
  endfunction

  // Accumulator datapath: loads on muxA=A, clears on op 14, otherwise holds.
  assign alu_acc = env_acc;
  always @(posedge clk) begin
    if (alu_op == 4'd14)         env_acc <= '0;
    else if (alu_muxA == 2'b10)  env_acc <= arith(alu_op, alu_A,
                                                  opb_sel(alu_muxB, alu_B, env_acc), env_acc);
  end

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       rsp_ready = 1'b0;
      2:       rsp_ready = ($urandom_range(0, 3) != 0);
      default: rsp_ready = 1'b1;
    endcase
  end

  always @(negedge clk) begin
    logic [15:0] eb;
    exp_t        e;
    if (reset && alu_muxA == 2'b10) begin
      eb = opb_sel(alu_muxB, alu_B, alu_acc);
      vectors++;
      if ((alu_op == 4'd1 && eb > alu_A) || (alu_op == 4'd3 && eb == 16'h0) ||
          alu_op == 4'd15) begin
        miscompares++;
        $display("FAIL issue_legal: op %0d A %0h effB %0h reached the ALU, required no faulting issue",
                 alu_op, alu_A, eb);
      end
    end
    if (reset && rsp_valid && rsp_ready) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL rsp_unexpected: data %0h err %0b, required no response", rsp_data, rsp_err);
      end else begin
        e = exp_q.pop_front();
        if (rsp_data !== e.data || rsp_err !== e.err || err_state !== e.errst) begin
          miscompares++;
          $display("FAIL rsp: data %0h err %0b err_state %0b, required data %0h err %0b err_state %0b",
                   rsp_data, rsp_err, err_state, e.data, e.err, e.errst);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Command-level reference: commands complete strictly in order.
  task automatic model_cmd(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                           input logic bsel);
    exp_t        e;
    logic [15:0] eb;
    eb = bsel ? m_acc[15:0] : b;
    if (m_err) begin
      if (op == 4'd14) begin
        m_err = 1'b0;
        m_acc = '0;
        e = '{32'h0, 1'b0, 1'b0};
      end else begin
        e = '{32'h0, 1'b1, 1'b1};
      end
    end else if ((op == 4'd1 && eb > a) || (op == 4'd3 && eb == 16'h0) || op == 4'd15) begin
      m_err = 1'b1;
      e = '{32'h0, 1'b1, 1'b1};
    end else begin
      m_acc = arith(op, a, eb, m_acc);
      e = '{m_acc, 1'b0, 1'b0};
    end
    exp_q.push_back(e);
  endtask

  task automatic push_cmd(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic bsel);
    bit ok = 1'b0;
    int t  = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_bsel  = bsel;
    while (!ok && t < 500) begin
      @(negedge clk);
      ok = cmd_ready;
      @(posedge clk);
      #1;
      t++;
    end
    cmd_valid = 1'b0;
    if (ok) model_cmd(op, a, b, bsel);
    else check("push_timeout", 32'(ok), 32'd1);
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((exp_q.size() != 0 || busy) && t < 2000) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("drain", 32'(t < 2000), 32'd1);
  endtask

  task automatic check_latency(input int exp_cyc, input string name, output bit saw_sub);
    int c = 0;
    saw_sub = 1'b0;
    while (c < 50) begin
      @(negedge clk);
      if (alu_op == 4'd1) saw_sub = 1'b1;
      if (rsp_valid) break;
      c++;
    end
    check(name, 32'(c), 32'(exp_cyc));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rsp_data"},  rsp_data,        32'd0);
    check({tag, "_rsp_err"},   32'(rsp_err),   32'd0);
    check({tag, "_busy"},      32'(busy),      32'd0);
    check({tag, "_err_state"}, 32'(err_state), 32'd0);
    check({tag, "_alu_A"},     32'(alu_A),     32'd0);
    check({tag, "_alu_B"},     32'(alu_B),     32'd0);
    check({tag, "_alu_op"},    32'(alu_op),    32'd14);
    check({tag, "_alu_muxA"},  32'(alu_muxA),  32'b01);
    check({tag, "_alu_muxB"},  32'(alu_muxB),  32'b1000);
  endtask

  task automatic apply_reset(input string tag);
    reset = 1'b0;
    #1;
    check_reset_vals(tag);
    exp_q.delete();
    m_acc = '0;
    m_err = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          saw_sub;
    bit          stalled;
    bit          rdy;
    int          accepted;
    int          t;
    logic [3:0]  ops_tab [7] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd13, 4'd14, 4'd15};
    logic [3:0]  r_op;
    logic [15:0] r_a, r_b;

    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Add, then add against the accumulator.
    push_cmd(4'd0, 16'd5, 16'd6, 1'b0);
    check_latency(2 + ALU_LAT, "lat_add", saw_sub);
    wait_drain();
    push_cmd(4'd0, 16'd42, 16'd0, 1'b1);
    wait_drain();

    // Underflow against acc = 53.
    push_cmd(4'd1, 16'd12, 16'd0, 1'b1);
    check_latency(2, "lat_fault", saw_sub);
    check("underflow_op1_seen", 32'(saw_sub), 32'd0);
    check("underflow_err_state", 32'(err_state), 32'd1);
    wait_drain();

    // Sticky error, cleared by op 14.
    push_cmd(4'd2, 16'd3, 16'd4, 1'b0);
    push_cmd(4'd14, 16'd0, 16'd0, 1'b0);
    wait_drain();
    check("err_cleared", 32'(err_state), 32'd0);

    // Multiply then divide by zero.
    push_cmd(4'd2, 16'd2048, 16'd16, 1'b0);
    push_cmd(4'd3, 16'd2048, 16'd0, 1'b0);
    push_cmd(4'd14, 16'd0, 16'd0, 1'b0);
    wait_drain();

    // Backpressure: one command moves into the FSM, the FIFO then fills.
    rdy_mode = 0;
    @(posedge clk);
    #2;
    accepted  = 0;
    stalled   = 1'b0;
    r_a       = 16'($urandom_range(0, 999));
    r_b       = 16'($urandom_range(0, 999));
    cmd_valid = 1'b1;
    cmd_op    = 4'd0;
    cmd_a     = r_a;
    cmd_b     = r_b;
    cmd_bsel  = 1'b0;
    for (int i = 0; i < 12 && !stalled; i++) begin
      @(negedge clk);
      rdy = cmd_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        model_cmd(4'd0, r_a, r_b, 1'b0);
        accepted++;
        r_a   = 16'($urandom_range(0, 999));
        r_b   = 16'($urandom_range(0, 999));
        cmd_a = r_a;
        cmd_b = r_b;
      end else begin
        stalled = 1'b1;
      end
    end
    cmd_valid = 1'b0;
    check("bp_accepted", 32'(accepted), 32'(DEPTH + 1));
    repeat (3) @(posedge clk);
    #1;
    check("bp_cmd_ready_low", 32'(cmd_ready), 32'd0);
    check("bp_busy", 32'(busy), 32'd1);
    rdy_mode = 1;
    wait_drain();

    // Async reset while the ALU is computing, with a second command queued.
    push_cmd(4'd0, 16'd100, 16'd200, 1'b0);
    push_cmd(4'd0, 16'd1, 16'd1, 1'b0);
    t = 0;
    while (alu_muxA != 2'b10 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("issue_seen", 32'(alu_muxA), 32'b10);
    @(posedge clk);
    #2;
    check("busy_in_wait", 32'(busy), 32'd1);
    apply_reset("rst_wait");
    repeat (20) @(posedge clk);
    #1;
    check("idle_after_reset", 32'(busy), 32'd0);
    push_cmd(4'd0, 16'd7, 16'd0, 1'b1);
    wait_drain();

    // Async reset while a faulted response is stalled.
    rdy_mode = 0;
    @(posedge clk);
    #2;
    push_cmd(4'd15, 16'd1, 16'd1, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("err_before_reset", 32'(err_state), 32'd1);
    check("rsp_stalled", 32'(rsp_valid), 32'd1);
    apply_reset("rst_resp");
    rdy_mode = 1;

    // Randomised traffic with random consumer backpressure.
    rdy_mode = 2;
    for (int i = 0; i < 150; i++) begin
      r_op = ops_tab[$urandom_range(0, 6)];
      r_a  = 16'($urandom);
      r_b  = ($urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom);
      push_cmd(r_op, r_a, r_b, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    rdy_mode = 1;
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
